// File: rtl/cv_ctrl_pkg.sv
// Shared ColecoVision controller definitions: keypad codes (pins {1,2,3,4}),
// keypad one-hot bit positions and the scanner state encoding.
package cv_ctrl_pkg;

    localparam logic [3:0] cv_key_0_c      = 4'b0011;
    localparam logic [3:0] cv_key_1_c      = 4'b1110;
    localparam logic [3:0] cv_key_2_c      = 4'b1101;
    localparam logic [3:0] cv_key_3_c      = 4'b0110;
    localparam logic [3:0] cv_key_4_c      = 4'b0001;
    localparam logic [3:0] cv_key_5_c      = 4'b1001;
    localparam logic [3:0] cv_key_6_c      = 4'b0111;
    localparam logic [3:0] cv_key_7_c      = 4'b1100;
    localparam logic [3:0] cv_key_8_c      = 4'b1000;
    localparam logic [3:0] cv_key_9_c      = 4'b1011;
    localparam logic [3:0] cv_key_star_c   = 4'b1010;
    localparam logic [3:0] cv_key_hash_c   = 4'b0101;
    localparam logic [3:0] cv_key_purple_c = 4'b0100;
    localparam logic [3:0] cv_key_blue_c   = 4'b0010;
    localparam logic [3:0] cv_key_none_c   = 4'b1111;
    localparam logic [3:0] cv_key_bad_c    = 4'b0000;

    localparam int unsigned KEY_WIDTH      = 14;
    localparam int unsigned KEY_BIT_STAR   = 10;
    localparam int unsigned KEY_BIT_HASH   = 11;
    localparam int unsigned KEY_BIT_PURPLE = 12;
    localparam int unsigned KEY_BIT_BLUE   = 13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_J_SETTLE = 3'd1,
        ST_J_SAMPLE = 3'd2,
        ST_J_GAP    = 3'd3,
        ST_K_SETTLE = 3'd4,
        ST_K_SAMPLE = 3'd5,
        ST_K_GAP    = 3'd6
    } scan_state_e;

endpackage

// File: rtl/cv_keycode_dec.sv
// Combinational keypad decoder: raw 4-bit pin code to one-hot key bits,
// with a flag for the illegal all-low code.
module cv_keycode_dec
    import cv_ctrl_pkg::*;
(
    input  logic [3:0]           code_i,
    output logic [KEY_WIDTH-1:0] keypad_o,
    output logic                 bad_o
);

    always_comb begin
        keypad_o = '0;
        bad_o    = 1'b0;
        case (code_i)
            cv_key_0_c:      keypad_o[0]              = 1'b1;
            cv_key_1_c:      keypad_o[1]              = 1'b1;
            cv_key_2_c:      keypad_o[2]              = 1'b1;
            cv_key_3_c:      keypad_o[3]              = 1'b1;
            cv_key_4_c:      keypad_o[4]              = 1'b1;
            cv_key_5_c:      keypad_o[5]              = 1'b1;
            cv_key_6_c:      keypad_o[6]              = 1'b1;
            cv_key_7_c:      keypad_o[7]              = 1'b1;
            cv_key_8_c:      keypad_o[8]              = 1'b1;
            cv_key_9_c:      keypad_o[9]              = 1'b1;
            cv_key_star_c:   keypad_o[KEY_BIT_STAR]   = 1'b1;
            cv_key_hash_c:   keypad_o[KEY_BIT_HASH]   = 1'b1;
            cv_key_purple_c: keypad_o[KEY_BIT_PURPLE] = 1'b1;
            cv_key_blue_c:   keypad_o[KEY_BIT_BLUE]   = 1'b1;
            cv_key_bad_c:    bad_o                    = 1'b1;
            default:         keypad_o                 = '0;
        endcase
    end

endmodule

// File: rtl/cv_ctrl_scanner.sv
// ColecoVision controller port scanner: alternates joystick/keypad select,
// samples synchronized pins, decodes and debounces the full-scan result.
module cv_ctrl_scanner
    import cv_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 32,
    parameter int unsigned DEBOUNCE_SCANS = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clk_en_i,
    input  logic                 enable_i,
    input  logic                 ctrl_p1_i,
    input  logic                 ctrl_p2_i,
    input  logic                 ctrl_p3_i,
    input  logic                 ctrl_p4_i,
    input  logic                 ctrl_p6_i,
    output logic                 ctrl_p5_o,
    output logic                 ctrl_p8_o,
    output logic [3:0]           joy_o,
    output logic [1:0]           fire_o,
    output logic [KEY_WIDTH-1:0] keypad_o,
    output logic                 bad_code_o,
    output logic                 scan_done_o
);

    localparam int unsigned SCW  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DBW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned CANDW = 4 + 2 + KEY_WIDTH + 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_TARGET   = DBW'(DEBOUNCE_SCANS);

    // Pin bit order inside the synchronizer: {p6, p4, p3, p2, p1}
    logic [4:0]           pin_meta_q, pin_sync_q;
    logic                 armed_q;

    scan_state_e          state_q, state_d;
    logic [SCW-1:0]       settle_q, settle_d;
    logic                 abort_q, abort_d;
    logic                 p5_q, p5_d, p8_q, p8_d;
    logic [3:0]           joy_cap_q, joy_cap_d;
    logic                 fire1_cap_q, fire1_cap_d;
    logic                 fire2_cap_q, fire2_cap_d;
    logic [3:0]           code_q, code_d;
    logic [CANDW-1:0]     hist_q, hist_d;
    logic [DBW-1:0]       db_cnt_q, db_cnt_d;
    logic [3:0]           joy_q, joy_d;
    logic [1:0]           fire_q, fire_d;
    logic [KEY_WIDTH-1:0] keypad_q, keypad_d;
    logic                 bad_q, bad_d;
    logic                 done_q, done_d;

    logic [KEY_WIDTH-1:0] dec_keypad;
    logic                 dec_bad;
    logic [CANDW-1:0]     candidate;
    logic                 step;

    cv_keycode_dec u_dec (
        .code_i   (code_q),
        .keypad_o (dec_keypad),
        .bad_o    (dec_bad)
    );

    assign candidate = {joy_cap_q, fire2_cap_q, fire1_cap_q, dec_keypad, dec_bad};
    // armed_q delays the first FSM step to the first enable after reset release
    assign step      = clk_en_i && armed_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        abort_d     = abort_q;
        joy_cap_d   = joy_cap_q;
        fire1_cap_d = fire1_cap_q;
        fire2_cap_d = fire2_cap_q;
        code_d      = code_q;
        hist_d      = hist_q;
        db_cnt_d    = db_cnt_q;
        joy_d       = joy_q;
        fire_d      = fire_q;
        keypad_d    = keypad_q;
        bad_d       = bad_q;
        done_d      = 1'b0;

        if (step) begin
            case (state_q)
                ST_IDLE: begin
                    abort_d  = 1'b0;
                    settle_d = '0;
                    hist_d   = '0;
                    db_cnt_d = '0;
                    if (enable_i) state_d = ST_J_SETTLE;
                end
                ST_J_SETTLE: begin
                    if (!enable_i) begin
                        state_d  = ST_J_GAP;
                        abort_d  = 1'b1;
                        settle_d = '0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_J_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_J_SAMPLE: begin
                    joy_cap_d   = ~pin_sync_q[3:0];
                    fire1_cap_d = ~pin_sync_q[4];
                    state_d     = ST_J_GAP;
                end
                ST_J_GAP: begin
                    if (!enable_i || abort_q) state_d = ST_IDLE;
                    else                      state_d = ST_K_SETTLE;
                end
                ST_K_SETTLE: begin
                    if (!enable_i) begin
                        state_d  = ST_K_GAP;
                        abort_d  = 1'b1;
                        settle_d = '0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_K_SAMPLE;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_K_SAMPLE: begin
                    code_d      = {pin_sync_q[0], pin_sync_q[1], pin_sync_q[2], pin_sync_q[3]};
                    fire2_cap_d = ~pin_sync_q[4];
                    state_d     = ST_K_GAP;
                end
                ST_K_GAP: begin
                    // An aborted scan is partial: no pulse, no debounce update
                    if (!abort_q) begin
                        done_d = 1'b1;
                        hist_d = candidate;
                        if ((db_cnt_q != '0) && (candidate == hist_q)) begin
                            db_cnt_d = (db_cnt_q == DB_TARGET) ? db_cnt_q : db_cnt_q + 1'b1;
                        end else begin
                            db_cnt_d = DBW'(1);
                        end
                        if (db_cnt_d == DB_TARGET) begin
                            joy_d    = joy_cap_q;
                            fire_d   = {fire2_cap_q, fire1_cap_q};
                            keypad_d = dec_keypad;
                            bad_d    = dec_bad;
                        end
                    end
                    abort_d = 1'b0;
                    state_d = (enable_i && !abort_q) ? ST_J_SETTLE : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Selects decode from a single next state, so they can never both be low
        p8_d = !((state_d == ST_J_SETTLE) || (state_d == ST_J_SAMPLE));
        p5_d = !((state_d == ST_K_SETTLE) || (state_d == ST_K_SAMPLE));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pin_meta_q  <= '1;
            pin_sync_q  <= '1;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            abort_q     <= 1'b0;
            p5_q        <= 1'b1;
            p8_q        <= 1'b1;
            joy_cap_q   <= '0;
            fire1_cap_q <= 1'b0;
            fire2_cap_q <= 1'b0;
            code_q      <= cv_key_none_c;
            hist_q      <= '0;
            db_cnt_q    <= '0;
            joy_q       <= '0;
            fire_q      <= '0;
            keypad_q    <= '0;
            bad_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pin_meta_q  <= {ctrl_p6_i, ctrl_p4_i, ctrl_p3_i, ctrl_p2_i, ctrl_p1_i};
            pin_sync_q  <= pin_meta_q;
            armed_q     <= 1'b1;
            state_q     <= state_d;
            settle_q    <= settle_d;
            abort_q     <= abort_d;
            p5_q        <= p5_d;
            p8_q        <= p8_d;
            joy_cap_q   <= joy_cap_d;
            fire1_cap_q <= fire1_cap_d;
            fire2_cap_q <= fire2_cap_d;
            code_q      <= code_d;
            hist_q      <= hist_d;
            db_cnt_q    <= db_cnt_d;
            joy_q       <= joy_d;
            fire_q      <= fire_d;
            keypad_q    <= keypad_d;
            bad_q       <= bad_d;
            done_q      <= done_d;
        end
    end

    assign ctrl_p5_o   = p5_q;
    assign ctrl_p8_o   = p8_q;
    assign joy_o       = joy_q;
    assign fire_o      = fire_q;
    assign keypad_o    = keypad_q;
    assign bad_code_o  = bad_q;
    assign scan_done_o = done_q;

endmodule

// File: tb/tb_cv_ctrl_scanner.sv
// Directed bench for cv_ctrl_scanner with a controller model that answers
// the select lines; expected values are hand-computed constants.
module tb_cv_ctrl_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        enable = 1'b0;
    logic        p1, p2, p3, p4, p6;
    logic        p5, p8;
    logic [3:0]  joy;
    logic [1:0]  fire;
    logic [13:0] keypad;
    logic        bad;
    logic        done;

    // Controller model: pins ordered {p1,p2,p3,p4}
    logic [3:0]  joy_pins = 4'hF;
    logic        joy_p6   = 1'b1;
    logic [3:0]  key_code = 4'hF;
    logic        key_p6   = 1'b1;

    int checks = 0;
    int failures = 0;
    int both_low = 0;

    cv_ctrl_scanner #(.SETTLE_CYCLES(32), .DEBOUNCE_SCANS(2)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .clk_en_i    (clk_en),
        .enable_i    (enable),
        .ctrl_p1_i   (p1),
        .ctrl_p2_i   (p2),
        .ctrl_p3_i   (p3),
        .ctrl_p4_i   (p4),
        .ctrl_p6_i   (p6),
        .ctrl_p5_o   (p5),
        .ctrl_p8_o   (p8),
        .joy_o       (joy),
        .fire_o      (fire),
        .keypad_o    (keypad),
        .bad_code_o  (bad),
        .scan_done_o (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (!p8) begin
            {p1, p2, p3, p4} = joy_pins;
            p6 = joy_p6;
        end else if (!p5) begin
            {p1, p2, p3, p4} = key_code;
            p6 = key_p6;
        end else begin
            {p1, p2, p3, p4} = 4'hF;
            p6 = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!p5 && !p8) both_low++;
    end

    function automatic logic [13:0] key_exp(input int c);
        case (c)
            1:  key_exp = 14'h0010;
            2:  key_exp = 14'h2000;
            3:  key_exp = 14'h0001;
            4:  key_exp = 14'h1000;
            5:  key_exp = 14'h0800;
            6:  key_exp = 14'h0008;
            7:  key_exp = 14'h0040;
            8:  key_exp = 14'h0100;
            9:  key_exp = 14'h0020;
            10: key_exp = 14'h0400;
            11: key_exp = 14'h0200;
            12: key_exp = 14'h0080;
            13: key_exp = 14'h0004;
            14: key_exp = 14'h0002;
            default: key_exp = 14'h0000;
        endcase
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s scan_done timeout after %0d cycles, expected pulse", tag, n);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        clk_en  = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({p5, p8} !== 2'b11) begin
            failures++;
            $display("FAIL reset_selects got %b expected 11", {p5, p8});
        end
        checks++;
        if ({joy, fire, keypad, bad, done} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h expected 0", {joy, fire, keypad, bad, done});
        end
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (p8 && n < 10);
        checks++;
        if (p8 !== 1'b0 || n > 3) begin
            failures++;
            $display("FAIL p8_assert got p8=%b after %0d cycles expected 0 within 3", p8, n);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        checks++;
        if (n != 68) begin
            failures++;
            $display("FAIL scan_period got %0d expected 68", n);
        end
        checks++;
        if ({joy, fire, keypad, bad} !== 21'd0) begin
            failures++;
            $display("FAIL idle_outputs got %h expected 0", {joy, fire, keypad, bad});
        end
    endtask

    task automatic test_joystick();
        joy_pins = 4'b0110;
        joy_p6   = 1'b0;
        key_code = 4'hF;
        key_p6   = 1'b1;
        do_reset();
        enable = 1'b1;
        wait_done("joy_scan1");
        checks++;
        if ({joy, fire} !== 6'd0) begin
            failures++;
            $display("FAIL joy_after_1 got joy=%b fire=%b expected 0000 00", joy, fire);
        end
        wait_done("joy_scan2");
        checks++;
        if (joy !== 4'b1001) begin
            failures++;
            $display("FAIL joy_after_2 got %b expected 1001", joy);
        end
        checks++;
        if (fire !== 2'b01) begin
            failures++;
            $display("FAIL fire_after_2 got %b expected 01", fire);
        end
    endtask

    task automatic test_keypad_sweep();
        joy_pins = 4'hF;
        joy_p6   = 1'b1;
        key_p6   = 1'b1;
        for (int c = 0; c < 16; c++) begin
            key_code = 4'(c);
            wait_done("sweep_a");
            wait_done("sweep_b");
            checks++;
            if (keypad !== key_exp(c)) begin
                failures++;
                $display("FAIL keypad_code_%0d got %h expected %h", c, keypad, key_exp(c));
            end
            checks++;
            if (bad !== (c == 0)) begin
                failures++;
                $display("FAIL bad_code_%0d got %b expected %b", c, bad, (c == 0));
            end
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) begin
            key_code = (i % 2 == 1) ? 4'b1101 : 4'b1110;
            wait_done("alt");
            checks++;
            if (keypad !== 14'h0000) begin
                failures++;
                $display("FAIL alternate_%0d got %h expected 0000", i, keypad);
            end
        end
    endtask

    task automatic test_abort();
        int n;
        key_code = 4'b0110;
        wait_done("abort_a1");
        wait_done("abort_a2");
        checks++;
        if (keypad !== 14'h0008) begin
            failures++;
            $display("FAIL abort_setup got %h expected 0008", keypad);
        end
        key_code = 4'b1110;
        wait_done("abort_b1");
        checks++;
        if (keypad !== 14'h0008) begin
            failures++;
            $display("FAIL abort_single_b got %h expected 0008", keypad);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (p5 && n < 100);
        enable = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p5 && p8) && n < 10);
        checks++;
        if (!(p5 && p8) || n > 2) begin
            failures++;
            $display("FAIL abort_selects got %b after %0d cycles expected 11 within 2", {p5, p8}, n);
        end
        repeat (6) @(negedge clk);
        checks++;
        if ({p5, p8, keypad} !== {2'b11, 14'h0008}) begin
            failures++;
            $display("FAIL abort_idle_hold got sel=%b keypad=%h expected 11 0008", {p5, p8}, keypad);
        end
        enable = 1'b1;
        wait_done("reen1");
        checks++;
        if (keypad !== 14'h0008) begin
            failures++;
            $display("FAIL reenable_scan1 got %h expected 0008", keypad);
        end
        wait_done("reen2");
        checks++;
        if (keypad !== 14'h0002) begin
            failures++;
            $display("FAIL reenable_scan2 got %h expected 0002", keypad);
        end
    endtask

    task automatic test_async_reset();
        key_code = 4'hF;
        joy_pins = 4'b0110;
        joy_p6   = 1'b0;
        wait_done("ar1");
        wait_done("ar2");
        repeat (32) @(negedge clk);
        checks++;
        if ({p8, joy, fire} !== {1'b0, 4'b1001, 2'b01}) begin
            failures++;
            $display("FAIL pre_reset got p8=%b joy=%b fire=%b expected 0 1001 01", p8, joy, fire);
        end
        clk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({p5, p8} !== 2'b11) begin
            failures++;
            $display("FAIL async_reset_selects got %b expected 11", {p5, p8});
        end
        checks++;
        if ({joy, fire, keypad, bad, done} !== 22'd0) begin
            failures++;
            $display("FAIL async_reset_outputs got %h expected 0", {joy, fire, keypad, bad, done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        clk_en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_joystick();
        test_keypad_sweep();
        test_alternate();
        test_abort();
        test_async_reset();
        checks++;
        if (both_low != 0) begin
            failures++;
            $display("FAIL select_overlap got %0d cycles expected 0", both_low);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
